cpu_commit_trace_buffer: RTL and testbench

//  Synthesizable successor to the per-cycle register dump. Sits beside sccpu and takes one commit

---
 rtl/cpu_commit_trace_buffer.sv | 114 +++++++++++
 tb/tb_cpu_commit_trace_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_commit_trace_buffer.sv
// cpu_commit_trace_buffer: buffers per-instruction commit records and streams each as four 32-bit trace words
//
// Optional feature: define TRACE_WB_FILTER_EN to capture only commits that write a non-zero register.
//
// Ports:
//   clk_in                   single clock, rising edge
//   reset                    synchronous, active-low
//   trace_en                 capture enable (drain continues when low)
//   commit_valid/pc/inst     retired instruction
//   commit_we/waddr/wdata    register writeback of that instruction
//   out_valid/ready/data     trace word stream; out_last marks word 3 of a record
//   level/full/empty         FIFO occupancy, including the record being sent
//   drop_count               records lost to overflow, saturating
module cpu_commit_trace_buffer #(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = $clog2(DEPTH),
    parameter logic [7:0] SYNC_BYTE = 8'hC3
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              trace_en,
    input  logic              commit_valid,
    input  logic [31:0]       commit_pc,
    input  logic [31:0]       commit_inst,
    input  logic              commit_we,
    input  logic [4:0]        commit_waddr,
    input  logic [31:0]       commit_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic [15:0]       drop_count
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [127:0]      mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, rd_next;
    logic [1:0]        widx;
    logic [7:0]        seq;
    logic              capture, consume, pop, push, drop;
    logic [127:0]      new_rec, cur_rec, next_rec;

`ifdef TRACE_WB_FILTER_EN
    assign capture = commit_valid && trace_en && commit_we && commit_waddr != 5'd0;
`else
    assign capture = commit_valid && trace_en;
`endif

    assign consume = out_valid && out_ready;
    assign pop     = consume && widx == 2'd3;
    // a full FIFO still accepts a push when the head record leaves in the same cycle
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;
    assign level   = wr_ptr - rd_ptr;
    assign full    = level == (ADDR_W+1)'(DEPTH);
    assign empty   = level == '0;
    assign rd_next = rd_ptr + {{ADDR_W{1'b0}}, pop};

    // record layout, word 0 in the low bits
    assign new_rec = {commit_we ? commit_wdata : 32'd0, commit_inst, commit_pc,
                      SYNC_BYTE, seq, (|drop_count[15:8]) ? 8'hFF : drop_count[7:0],
                      commit_we, 2'b00, commit_waddr};
    assign cur_rec  = mem[rd_ptr[ADDR_W-1:0]];
    // bypass the incoming record when nothing else is queued, giving one-cycle latency
    assign next_rec = (wr_ptr != rd_next) ? mem[rd_next[ADDR_W-1:0]] : new_rec;

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr[ADDR_W-1:0]] <= new_rec;
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            widx       <= 2'd0;
            seq        <= 8'd0;
            drop_count <= 16'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 8'd1;
            end
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            rd_ptr <= rd_next;
            if (consume && widx != 2'd3) begin
                widx     <= widx + 2'd1;
                out_data <= cur_rec[{widx + 2'd1, 5'd0} +: 32];
                out_last <= widx == 2'd2;
            end else if (state == IDLE || pop) begin
                if (wr_ptr != rd_next || push) begin
                    state     <= SEND;
                    out_valid <= 1'b1;
                    widx      <= 2'd0;
                    out_data  <= next_rec[31:0];
                    out_last  <= 1'b0;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_commit_trace_buffer.sv
// tb_cpu_commit_trace_buffer: directed self-checking bench for cpu_commit_trace_buffer
module tb_cpu_commit_trace_buffer;
    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = 32'd0;
    logic [31:0] commit_inst = 32'd0;
    logic        commit_we = 1'b0;
    logic [4:0]  commit_waddr = 5'd0;
    logic [31:0] commit_wdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic [15:0] drop_count;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] single_words [4];

    cpu_commit_trace_buffer dut (
        .clk_in(clk_in), .reset(reset), .trace_en(trace_en),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_we(commit_we), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .level(level), .full(full), .empty(empty), .drop_count(drop_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        commit_valid = 1'b0;
        out_ready = 1'b0;
        trace_en = 1'b1;
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                              input logic [4:0] waddr, input logic [31:0] wdata);
        commit_pc = pc;
        commit_inst = inst;
        commit_we = we;
        commit_waddr = waddr;
        commit_wdata = wdata;
        commit_valid = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                            input logic [4:0] waddr, input logic [31:0] wdata);
        set_commit(pc, inst, we, waddr, wdata);
        tick;
        commit_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        commit_valid = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_out: valid=%b last=%b data=%h expected 0 0 00000000", out_valid, out_last, out_data);
        end
        tests++;
        if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_status: level=%0d empty=%b full=%b drops=%0d expected 0 1 0 0", level, empty, full, drop_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_single;
        apply_reset;
        out_ready = 1'b1;
        push_one(32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== single_words[i] || out_last !== (i == 3)) begin
                fails++;
                $display("FAIL single_w%0d: valid=%b data=%h last=%b expected 1 %h %b", i, out_valid, out_data, out_last, single_words[i], i == 3);
            end
            tick;
        end
        tests++;
        if (out_valid !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL single_end: valid=%b empty=%b expected 0 1", out_valid, empty);
        end
    endtask

    task automatic test_backpressure;
        apply_reset;
        out_ready = 1'b0;
        push_one(32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hC300_0081 || out_last !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b data=%h last=%b expected 1 c3000081 0", i, out_valid, out_data, out_last);
            end
            tick;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== single_words[i] || out_last !== (i == 3)) begin
                fails++;
                $display("FAIL bp_w%0d: valid=%b data=%h last=%b expected 1 %h %b", i, out_valid, out_data, out_last, single_words[i], i == 3);
            end
            tick;
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_end: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] exp;
        apply_reset;
        out_ready = 1'b0;
        for (int r = 0; r < 20; r++) begin
            set_commit(32'h1000 + r, 32'hA000_0000 + r, 1'b1, 5'(r + 1), 32'h5000 + r);
            tick;
        end
        commit_valid = 1'b0;
        tests++;
        if (full !== 1'b1 || level !== 5'd16 || drop_count !== 16'd4) begin
            fails++;
            $display("FAIL ovf_status: full=%b level=%0d drops=%0d expected 1 16 4", full, level, drop_count);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < 4; w++) begin
                exp = (w == 0) ? {8'hC3, 8'(r), 8'h00, 3'b100, 5'(r + 1)} :
                      (w == 1) ? 32'h1000 + r :
                      (w == 2) ? 32'hA000_0000 + r : 32'h5000 + r;
                tests++;
                if (out_valid !== 1'b1 || out_data !== exp || out_last !== (w == 3)) begin
                    fails++;
                    $display("FAIL ovf_r%0d_w%0d: valid=%b data=%h last=%b expected 1 %h %b", r, w, out_valid, out_data, out_last, exp, w == 3);
                end
                tick;
            end
        end
        tests++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || drop_count !== 16'd4) begin
            fails++;
            $display("FAIL ovf_end: valid=%b empty=%b drops=%0d expected 0 1 4", out_valid, empty, drop_count);
        end
    endtask

    task automatic test_simultaneous;
        apply_reset;
        out_ready = 1'b0;
        for (int r = 0; r < 16; r++) begin
            set_commit(32'h2000 + r, 32'hB000_0000 + r, 1'b1, 5'(r + 1), 32'h6000 + r);
            tick;
        end
        commit_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        tick;
        tests++;
        if (out_last !== 1'b1 || out_data !== 32'h6000 || full !== 1'b1) begin
            fails++;
            $display("FAIL sim_w3: last=%b data=%h full=%b expected 1 00006000 1", out_last, out_data, full);
        end
        push_one(32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 5'd7, 32'h0000_1234);
        tests++;
        if (level !== 5'd16 || full !== 1'b1 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL sim_status: level=%0d full=%b drops=%0d expected 16 1 0", level, full, drop_count);
        end
        tests++;
        if (out_data !== 32'hC301_0082) begin
            fails++;
            $display("FAIL sim_next_hdr: data=%h expected c3010082", out_data);
        end
        repeat (60) tick;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hC310_0087) begin
            fails++;
            $display("FAIL sim_new_hdr: valid=%b data=%h expected 1 c3100087", out_valid, out_data);
        end
        tick;
        tests++;
        if (out_data !== 32'hDEAD_0000) begin
            fails++;
            $display("FAIL sim_new_pc: data=%h expected dead0000", out_data);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] hdr;
        apply_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            hdr = {8'hC3, 8'(i), 8'h00, 8'h83};
            push_one(32'h0040_0000 + 32'(i * 4), 32'(i), 1'b1, 5'd3, 32'h7700_0000 + 32'(i));
            tests++;
            if (out_valid !== 1'b1 || out_data !== hdr) begin
                fails++;
                $display("FAIL wrap_hdr%0d: valid=%b data=%h expected 1 %h", i, out_valid, out_data, hdr);
            end
            tick;
            tests++;
            if (out_data !== 32'h0040_0000 + 32'(i * 4)) begin
                fails++;
                $display("FAIL wrap_pc%0d: data=%h expected %h", i, out_data, 32'h0040_0000 + 32'(i * 4));
            end
            tick;
            tick;
            tests++;
            if (out_last !== 1'b1 || out_data !== 32'h7700_0000 + 32'(i)) begin
                fails++;
                $display("FAIL wrap_w3_%0d: last=%b data=%h expected 1 %h", i, out_last, out_data, 32'h7700_0000 + 32'(i));
            end
            tick;
        end
        tests++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || level !== 5'd0 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL wrap_end: valid=%b empty=%b level=%0d drops=%0d expected 0 1 0 0", out_valid, empty, level, drop_count);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset;
        out_ready = 1'b0;
        for (int r = 0; r < 18; r++) begin
            set_commit(32'h3000 + r, 32'h0, 1'b1, 5'd1, 32'h1);
            tick;
        end
        commit_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        tests++;
        if (out_data !== 32'h3000 || drop_count !== 16'd2) begin
            fails++;
            $display("FAIL mid_pre: data=%h drops=%0d expected 00003000 2", out_data, drop_count);
        end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b level=%0d drops=%0d last=%b expected 0 0 0 0", out_valid, level, drop_count, out_last);
        end
        push_one(32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hC300_0081) begin
            fails++;
            $display("FAIL mid_hdr: valid=%b data=%h expected 1 c3000081", out_valid, out_data);
        end
    endtask

    task automatic test_capture_gating;
        apply_reset;
        out_ready = 1'b1;
        trace_en = 1'b0;
        push_one(32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        tests++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL gate_trace_en: valid=%b level=%0d expected 0 0", out_valid, level);
        end
        trace_en = 1'b1;
        push_one(32'h0040_0010, 32'h0000_0000, 1'b0, 5'd0, 32'hDEAD_BEEF);
`ifdef TRACE_WB_FILTER_EN
        tests++;
        if (out_valid !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL filt_we0: valid=%b level=%0d drops=%0d expected 0 0 0", out_valid, level, drop_count);
        end
        push_one(32'h0040_0014, 32'h0000_0000, 1'b1, 5'd0, 32'h1);
        tests++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL filt_x0: valid=%b level=%0d expected 0 0", out_valid, level);
        end
`else
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hC300_0000) begin
            fails++;
            $display("FAIL nofilt_hdr: valid=%b data=%h expected 1 c3000000", out_valid, out_data);
        end
        tick;
        tick;
        tick;
        tests++;
        if (out_last !== 1'b1 || out_data !== 32'd0) begin
            fails++;
            $display("FAIL nofilt_w3: last=%b data=%h expected 1 00000000", out_last, out_data);
        end
`endif
    endtask

    initial begin
        single_words[0] = 32'hC300_0081;
        single_words[1] = 32'h0040_0000;
        single_words[2] = 32'h2401_0005;
        single_words[3] = 32'h0000_0005;
        test_reset;
        test_single;
        test_backpressure;
        test_overflow;
        test_simultaneous;
        test_wrap;
        test_reset_mid;
        test_capture_gating;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
